// File: rtl/salsa_stream_xor.sv
// salsa_stream_xor: iterative Salsa20 keystream generator (one double-round per cycle)
// XORed word-by-word into a 32-bit valid/ready stream.
module salsa_stream_xor #(
   parameter int ROUNDS = 20
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [255:0] key_in,
   input  logic [63:0]  nonce_in,
   input  logic [63:0]  counter_in,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [31:0]  s_data,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [31:0]  m_data,
   output logic [63:0]  blk_ctr,
   output logic         busy
);
   localparam int HALF = ROUNDS / 2;

   typedef enum logic [1:0] {IDLE, GEN, STREAM} state_t;
   state_t state, state_nx;

   logic [255:0] key_r;
   logic [63:0]  nonce_r;
   logic [511:0] x, x_nx, init, fin, ks;
   logic [3:0]   rnd, idx;
   logic         last, hs;

   function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
      return (v << n) | (v >> (32 - n));
   endfunction

   function automatic logic [127:0] qr(input logic [31:0] a, b, c, d);
      logic [31:0] a2, b2, c2, d2;
      b2 = b ^ rotl(a + d, 7);
      c2 = c ^ rotl(b2 + a, 9);
      d2 = d ^ rotl(c2 + b2, 13);
      a2 = a ^ rotl(d2 + c2, 18);
      return {a2, b2, c2, d2};
   endfunction

   // column round followed by row round
   function automatic logic [511:0] dround(input logic [511:0] s);
      logic [31:0]  y [16];
      logic [511:0] r;
      for (int i = 0; i < 16; i++) y[i] = s[32*i +: 32];
      {y[0], y[4], y[8], y[12]}   = qr(y[0], y[4], y[8], y[12]);
      {y[5], y[9], y[13], y[1]}   = qr(y[5], y[9], y[13], y[1]);
      {y[10], y[14], y[2], y[6]}  = qr(y[10], y[14], y[2], y[6]);
      {y[15], y[3], y[7], y[11]}  = qr(y[15], y[3], y[7], y[11]);
      {y[0], y[1], y[2], y[3]}    = qr(y[0], y[1], y[2], y[3]);
      {y[5], y[6], y[7], y[4]}    = qr(y[5], y[6], y[7], y[4]);
      {y[10], y[11], y[8], y[9]}  = qr(y[10], y[11], y[8], y[9]);
      {y[15], y[12], y[13], y[14]} = qr(y[15], y[12], y[13], y[14]);
      for (int i = 0; i < 16; i++) r[32*i +: 32] = y[i];
      return r;
   endfunction

   function automatic logic [511:0] mtx(input logic [255:0] k, input logic [63:0] n, input logic [63:0] c);
      return {32'h6B206574, k[255:128], 32'h79622D32, c, n, 32'h3320646E, k[127:0], 32'h61707865};
   endfunction

   always_comb begin
      init = mtx(key_r, nonce_r, blk_ctr);
      x_nx = dround(x);
      for (int i = 0; i < 16; i++) fin[32*i +: 32] = x_nx[32*i +: 32] + init[32*i +: 32];
   end

   assign last = (rnd == 4'(HALF - 1));

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nx;

   // start masks the handshake so no word is lost across a restart
   always_comb begin
      state_nx = state;
      busy     = (state != IDLE);
      s_ready  = (state == STREAM) && m_ready && !start;
      m_valid  = (state == STREAM) && s_valid && !start;
      m_data   = (state == STREAM) ? s_data ^ ks[{idx, 5'd0} +: 32] : 32'd0;
      hs       = s_valid && s_ready;
      if (start) state_nx = GEN;
      else if (state == GEN && last) state_nx = STREAM;
      else if (hs && idx == 4'd15) state_nx = GEN;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         key_r   <= '0;
         nonce_r <= '0;
         blk_ctr <= '0;
         x       <= '0;
         ks      <= '0;
         rnd     <= '0;
         idx     <= '0;
      end else if (start) begin
         key_r   <= key_in;
         nonce_r <= nonce_in;
         blk_ctr <= counter_in;
         x       <= mtx(key_in, nonce_in, counter_in);
         rnd     <= '0;
         idx     <= '0;
      end else if (state == GEN) begin
         x   <= x_nx;
         rnd <= last ? 4'd0 : rnd + 4'd1;
         if (last) begin
            ks  <= fin;
            idx <= '0;
         end
      end else if (hs) begin
         idx <= idx + 4'd1;
         if (idx == 4'd15) begin
            blk_ctr <= blk_ctr + 64'd1;
            x       <= mtx(key_r, nonce_r, blk_ctr + 64'd1);
         end
      end
endmodule

// File: doc/salsa_stream_xor.md
# salsa_stream_xor

Sequential Salsa20 stream-cipher engine: the consumer and driver of the `salsa_hash` keystream interface. It loads key/nonce/initial block counter, generates each 512-bit keystream block iteratively (one double-round per cycle), and XORs it word-by-word into a 32-bit valid/ready data stream. Encryption and decryption are the same operation. It sits between a data source and sink in the cipher datapath and produces keystream bit-identical to `salsa_hash` for the same key/nonce/counter.

## Interface
- `ROUNDS`, 20, number of Salsa rounds; must be even, one of 8/12/20.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  load pulse; samples `key_in`, `nonce_in`, `counter_in`; accepted in any state (restart).
- `key_in`  in  256  key; key word i = `key_in[32i+31:32i]`, little-endian bytes (byte 0 = `key_in[7:0]`).
- `nonce_in`  in  64  nonce; word 6 = `[31:0]`, word 7 = `[63:32]`.
- `counter_in`  in  64  initial block counter; word 8 = `[31:0]`, word 9 = `[63:32]`.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  input word accepted when `s_valid & s_ready`.
- `s_data`  in  32  plaintext/ciphertext word.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  sink ready.
- `m_data`  out  32  `s_data ^ ks[idx]`.
- `blk_ctr`  out  64  block counter of the current/pending keystream block.
- `busy`  out  1  high in every state except IDLE.

## Operation
- State matrix: constants 0x61707865, 0x3320646E, 0x79622D32, 0x6B206574 at words 0/5/10/15; key words 0–3 at 1–4, 4–7 at 11–14; nonce at 6–7; counter at 8–9.
- FSM IDLE -> GEN -> STREAM -> GEN -> ...
- IDLE: `s_ready`=0, `m_valid`=0. `start` -> GEN with registered key/nonce, `blk_ctr`=`counter_in`, x = initial matrix, round count 0.
- GEN: each cycle applies one column round + one row round to x. On the ROUNDS/2-th GEN edge, `ks[i]` = x'[i] + init[i] (mod 2^32 per word), `idx`=0 -> STREAM.
- STREAM: `s_ready` = `m_ready`; `m_valid` = `s_valid`; `m_data` = `s_data ^ ks[idx]` (combinational pass-through, zero latency). Each handshake increments `idx`; handshake at `idx`=15 -> `blk_ctr` += 1 (64-bit wrap, 2^64−1 -> 0), reload x from the new matrix, -> GEN.
- Keystream word ordering: `ks[i]` equals `salsa_hash` `digest_out[32i+31:32i]`; keystream byte 0 = `ks[0][7:0]`.
- `start` while busy: aborts current block, discards remaining `ks`, reloads; behaves as from IDLE. No words are transferred on the `start` edge.
- No handshake is possible outside STREAM; the bench must not expect buffered input.

## Timing
- Reset values: state IDLE, `s_ready`=0, `m_valid`=0, `m_data`=0 (gated when not STREAM), `blk_ctr`=0, `busy`=0, `idx`=0, `ks`/x cleared.
- Async reset mid-GEN or mid-STREAM: immediate return to IDLE; a partially transferred block is lost.
- Start latency: `start` sampled at edge E0; GEN occupies E1..E(ROUNDS/2); `s_ready` may rise after E(ROUNDS/2) (10 cycles for ROUNDS=20).
- Steady state: 16 words per block, then ROUNDS/2 dead cycles (`s_ready`=0) per block refill.
- `m_ready`=0 in STREAM: `s_ready`=0, `idx` and `ks` hold indefinitely.
- `s_valid`=0: `m_valid`=0, no index advance.

## Test plan
- Key 256'h80, nonce 0, counter 0, ROUNDS=20, `s_data`=0, `m_ready`=1 -> `m_data` words 0–3 = DD8FBEE3, E3A2EC8B, 47F98EEA, E7A6295B; word 15 = 17A1F17E; words 16, 17 (block 1) = 4EB7A28D, 83621BEF; `blk_ctr` 0 -> 1 after word 15.
- Latency: `start` at E0 -> `s_ready`=0 through E10, =1 after E10; after word 15, `s_ready`=0 for exactly 10 cycles.
- Backpressure: drop `m_ready` for 7 cycles at idx 4 -> no handshakes, word 4 emitted unchanged when `m_ready` returns; random `s_valid` gaps give an identical 32-word stream.
- Round-trip: encrypt 48 random words, restart with same key/nonce/counter, feed ciphertext -> original plaintext recovered.
- Counter wrap: `counter_in` = 64'hFFFFFFFF_FFFFFFFF -> after 16 words `blk_ctr`=0 and next block equals the counter-0 block (word 0 = DD8FBEE3 with key 256'h80).
- Restart/reset: `start` at idx 5 with counter 1 -> next output is block-1 word 0 (4EB7A28D) after 10 cycles; `rst` asserted mid-GEN -> all outputs at reset values without a clock edge.
